// File: rtl/seq_seg_mult_pkg.sv
// seq_seg_mult_pkg: FSM state type, 7-seg constants and digit-count helper.
package seq_seg_mult_pkg;

    typedef enum logic [1:0] {IDLE, MUL, CONV, DONE} state_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic int dec_digits(input int w);
        logic [63:0] m;
        int n;
        m = ((64'd1 << w) - 64'd1) * ((64'd1 << w) - 64'd1);
        n = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_seg_mult_seg7_decoder.sv
// seg7_decoder: BCD nibble plus blank to active-low 7-seg pattern (a..g from MSB).
module seg7_decoder
    import seq_seg_mult_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank)
            case (bcd)
                4'd0: seg = SEG_0;
                4'd1: seg = SEG_1;
                4'd2: seg = SEG_2;
                4'd3: seg = SEG_3;
                4'd4: seg = SEG_4;
                4'd5: seg = SEG_5;
                4'd6: seg = SEG_6;
                4'd7: seg = SEG_7;
                4'd8: seg = SEG_8;
                4'd9: seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
    end

endmodule

// File: rtl/seq_seg_mult.sv
// seq_seg_mult: sequential shift-add multiplier with double-dabble BCD and 7-seg outputs.
module seq_seg_mult
    import seq_seg_mult_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3,
    parameter int LZB    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    product,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BW = 4 * DIGITS;
    localparam int DW = BW + 2 * WIDTH;

    if (DIGITS < dec_digits(WIDTH)) begin : g_bad_digits
        $error("seq_seg_mult: DIGITS too small for WIDTH");
    end

    state_t               state, state_nxt;
    logic [5:0]           cnt;
    logic                 last;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   mcand, acc, acc_nxt;
    logic [DW-1:0]        dd, dd_adj, dd_nxt;
    logic [BW-1:0]        bcd_nxt;
    logic [DIGITS-1:0]    blank;
    logic [7*DIGITS-1:0]  seg_nxt;

    assign busy    = (state == MUL) || (state == CONV);
    assign done    = (state == DONE);
    assign last    = cnt == ((state == MUL) ? 6'(WIDTH - 1) : 6'(2 * WIDTH - 1));
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign dd_nxt  = dd_adj << 1;
    assign bcd_nxt = BW'(dd_nxt >> (2 * WIDTH));

    always_comb begin
        dd_adj = dd;
        for (int i = 0; i < DIGITS; i++)
            if (dd[2*WIDTH+4*i +: 4] >= 4'd5)
                dd_adj[2*WIDTH+4*i +: 4] = dd[2*WIDTH+4*i +: 4] + 4'd3;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign blank[i] = (LZB != 0) && (i != 0) && (bcd_nxt[BW-1:4*i] == '0);
        seg7_decoder u_dec (
            .bcd   (bcd_nxt[4*i +: 4]),
            .blank (blank[i]),
            .seg   (seg_nxt[7*i +: 7])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? MUL : IDLE;
            MUL:     state_nxt = last ? CONV : MUL;
            CONV:    state_nxt = last ? DONE : CONV;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mplier  <= '0;
            mcand   <= '0;
            acc     <= '0;
            dd      <= '0;
            product <= '0;
            bcd     <= '0;
            seg     <= {DIGITS{SEG_BLANK}};
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    mplier <= b;
                    mcand  <= {{WIDTH{1'b0}}, a};
                    acc    <= '0;
                    cnt    <= '0;
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= last ? 6'd0 : cnt + 6'd1;
                    if (last)
                        dd <= {{BW{1'b0}}, acc_nxt};
                end
                CONV: begin
                    dd  <= dd_nxt;
                    cnt <= last ? 6'd0 : cnt + 6'd1;
                    if (last) begin
                        product <= acc;
                        bcd     <= bcd_nxt;
                        seg     <= seg_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_seg_mult.sv
// tb_seq_seg_mult: directed checks of seq_seg_mult across three parameterisations.
module tb_seq_seg_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start4, start4z, start8;
    logic [3:0]  a4, b4, a4z, b4z;
    logic [7:0]  a8, b8;
    logic        busy4, busy4z, busy8, done4, done4z, done8;
    logic [7:0]  product4, product4z;
    logic [15:0] product8;
    logic [11:0] bcd4, bcd4z;
    logic [19:0] bcd8;
    logic [20:0] seg4, seg4z;
    logic [34:0] seg8;

    int n_chk  = 0;
    int n_fail = 0;

    seq_seg_mult #(.WIDTH(4), .DIGITS(3), .LZB(0)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(product4), .bcd(bcd4), .seg(seg4));

    seq_seg_mult #(.WIDTH(4), .DIGITS(3), .LZB(1)) u4z (
        .clk(clk), .rst(rst), .start(start4z), .a(a4z), .b(b4z),
        .busy(busy4z), .done(done4z), .product(product4z), .bcd(bcd4z), .seg(seg4z));

    seq_seg_mult #(.WIDTH(8), .DIGITS(5), .LZB(0)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8), .bcd(bcd8), .seg(seg8));

    localparam logic [6:0] BL = 7'b1111111;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return BL;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int sel, input int limit, output int n);
        logic d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            d = (sel == 0) ? done4 : (sel == 1) ? done4z : done8;
        end while (!d && n < limit);
    endtask

    initial begin
        int n, seen, v;
        rst = 1'b1;
        start4 = 0; start4z = 0; start8 = 0;
        a4 = 0; b4 = 0; a4z = 0; b4z = 0; a8 = 0; b8 = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {busy4, busy4z, busy8}, 3'b000);
        chk("rst_done", {done4, done4z, done8}, 3'b000);
        chk("rst_product", {product4, product4z, product8}, 64'd0);
        chk("rst_bcd", {bcd4, bcd4z, bcd8}, 64'd0);
        chk("rst_seg4", seg4, {3{BL}});
        chk("rst_seg8", seg8, {5{BL}});
        rst = 1'b0;
        @(negedge clk);

        // 15*15 latency and result
        a4 = 15; b4 = 15; start4 = 1;
        @(negedge clk);
        start4 = 0;
        chk("busy_mul", busy4, 1'b1);
        wait_done(0, 40, n);
        chk("lat_w4", n + 1, 13);
        chk("busy_done", busy4, 1'b0);
        chk("prod_225", product4, 8'd225);
        chk("bcd_225", bcd4, 12'h225);
        chk("seg_225", seg4, {7'b0010010, 7'b0010010, 7'b0100100});
        @(negedge clk);
        chk("done_pulse", done4, 1'b0);
        chk("hold_prod", product4, 8'd225);

        // leading-zero blanking
        a4z = 0; b4z = 7; start4z = 1;
        wait_done(1, 40, n);
        start4z = 0;
        chk("lzb_prod0", product4z, 8'd0);
        chk("lzb_seg0", seg4z, {BL, BL, 7'b0000001});
        chk("lzb_bcd0", bcd4z, 12'h000);
        @(negedge clk);
        a4z = 3; b4z = 3; start4z = 1;
        wait_done(1, 40, n);
        start4z = 0;
        chk("lzb_seg9", seg4z, {BL, BL, 7'b0000100});
        @(negedge clk);
        a4z = 10; b4z = 10; start4z = 1;
        wait_done(1, 40, n);
        start4z = 0;
        chk("lzb_bcd100", bcd4z, 12'h100);
        chk("lzb_seg100", seg4z, {7'b1001111, 7'b0000001, 7'b0000001});

        // start during operation ignored
        @(negedge clk);
        a4 = 5; b4 = 5; start4 = 1;
        @(negedge clk);
        start4 = 0;
        repeat (4) @(negedge clk);
        a4 = 1; b4 = 1; start4 = 1;
        @(negedge clk);
        start4 = 0;
        wait_done(0, 40, n);
        chk("ign_lat", n + 6, 13);
        chk("ign_prod", product4, 8'd25);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done4 || busy4) seen++;
        end
        chk("ign_noqueue", seen, 0);

        // 255*255 at WIDTH=8
        a8 = 255; b8 = 255; start8 = 1;
        wait_done(2, 60, n);
        start8 = 0;
        chk("lat_w8", n, 25);
        chk("prod_65025", product8, 16'd65025);
        chk("bcd_65025", bcd8, 20'h65025);
        chk("seg_65025", seg8, {seg_of(6), seg_of(5), seg_of(0), seg_of(2), seg_of(5)});

        // exhaustive sweep, start held high
        @(negedge clk);
        a4 = 0; b4 = 0; start4 = 1;
        for (int i = 0; i < 256; i++) begin
            wait_done(0, 40, n);
            v = (i / 16) * (i % 16);
            chk("sweep_gap", n, (i == 0) ? 13 : 14);
            chk("sweep_prod", product4, v);
            chk("sweep_bcd", bcd4, {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
            chk("sweep_seg", seg4, {seg_of(v / 100), seg_of((v / 10) % 10), seg_of(v % 10)});
            if (i < 255) begin
                a4 = 4'((i + 1) / 16);
                b4 = 4'((i + 1) % 16);
            end
        end
        start4 = 0;
        repeat (2) @(negedge clk);

        // reset aborts an operation
        a4 = 15; b4 = 15; start4 = 1;
        @(negedge clk);
        start4 = 0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy4, 1'b0);
        chk("abort_done", done4, 1'b0);
        chk("abort_prod", product4, 8'd0);
        chk("abort_bcd", bcd4, 12'h000);
        chk("abort_seg", seg4, {3{BL}});
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done4) seen++;
        end
        chk("abort_nodone", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_seg_mult.md
SEQ_SEG_MULT -- requirements
Module: seq_seg_mult

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits (legal 2..16).
REQ-002 Parameter DIGITS, default 3, number of BCD/7-seg digits; SHALL be at least the decimal digit count of (2^WIDTH-1)^2.
REQ-003 Parameter LZB, default 0, leading-zero blanking enable (1 = blank leading zero digits).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 start  in  1  request to multiply a by b; sampled only in IDLE.
REQ-007 a  in  WIDTH  multiplicand, unsigned.
REQ-008 b  in  WIDTH  multiplier, unsigned.
REQ-009 busy  out  1  high while a computation is in progress.
REQ-010 done  out  1  one-cycle pulse when results are updated.
REQ-011 product  out  2*WIDTH  registered binary product.
REQ-012 bcd  out  4*DIGITS  registered packed BCD of the product; digit 0 (units) in bits [3:0].
REQ-013 seg  out  7*DIGITS  registered 7-seg patterns, digit i in bits [7i+6:7i]; bit order a,b,c,d,e,f,g from MSB; active-low.

Function
REQ-014 FSM states: IDLE, MUL, CONV, DONE.
REQ-015 IDLE: on start=1, latch a and b, clear accumulator, go to MUL; otherwise stay.
REQ-016 MUL: shift-add, one multiplier bit per cycle, LSB first; exactly WIDTH cycles, then CONV.
REQ-017 CONV: double-dabble binary-to-BCD, one shift per cycle, add-3 to every BCD nibble >=5 before each shift; exactly 2*WIDTH cycles, then DONE.
REQ-018 DONE: product, bcd and seg update together; done=1 for this single cycle; next state IDLE.
REQ-019 Latency: done SHALL be high in the cycle that begins 3*WIDTH+1 rising edges after the edge that sampled start.
REQ-020 busy=1 in MUL and CONV only; busy=0 in IDLE and DONE.
REQ-021 start while in MUL, CONV or DONE SHALL be ignored; no queuing. Changes on a or b after acceptance have no effect.
REQ-022 Back-to-back: start held high continuously yields one accepted operation per 3*WIDTH+2 cycles.
REQ-023 Arithmetic unsigned; product exact in 2*WIDTH bits, no truncation.
REQ-024 Segment codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; any other nibble or blanked digit = 1111111.
REQ-025 LZB=1: every zero digit above the most significant nonzero digit blanked; digit 0 never blanked (product 0 shows "0"). bcd output never blanked.
REQ-026 product, bcd, seg hold the last result between DONE cycles.

Reset
REQ-027 rst=1 at a rising edge: state IDLE, busy=0, done=0, product=0, bcd=0, every seg digit=1111111, internal registers cleared.
REQ-028 rst during MUL or CONV aborts; no done pulse for the aborted operation; rst has priority over start.

Structure
REQ-029 Package seq_seg_mult_pkg holds the FSM state type, the ten segment constants plus blank constant, and a constant function computing decimal digit count for a given WIDTH.
REQ-030 One sub-module: seg7_decoder (4-bit BCD plus blank input -> 7-bit pattern, combinational), instantiated DIGITS times.
REQ-031 Elaboration-time check SHALL fail if DIGITS is below the package-computed minimum.

Verification
REQ-032 WIDTH=4, DIGITS=3: a=15,b=15,start -> done after 13 edges, product=225, bcd=0x225, seg={0010010,0010010,0100100}.
REQ-033 WIDTH=4, LZB=1: a=0,b=7 -> product=0, seg={1111111,1111111,0000001}; a=3,b=3 -> seg={1111111,1111111,0000100}.
REQ-034 start pulsed again at cycle 5 of an operation with a=1,b=1 -> ignored, first result 5*5=25 reported, single done pulse.
REQ-035 rst asserted at cycle 6 of 15*15 -> busy=0 next cycle, no done, seg all 1111111, product=0.
REQ-036 WIDTH=8, DIGITS=5: a=255,b=255 -> done after 25 edges, product=65025, bcd=0x65025.
REQ-037 Exhaustive WIDTH=4 sweep of all 256 pairs against a reference model with start held high -> all results match, spacing 14 cycles.
